// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
//   Shared definitions for the CPU memory subsystem: default RAM geometry
//   used by the ram instance, the Cpu and mem_port_arbiter, the arbiter
//   FSM state encoding and the requester IDs.
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // The numeric value doubles as the bit position in the rvalid vector.
    typedef enum logic [1:0] {
        REQ_F = 2'd0,
        REQ_D = 2'd1,
        REQ_X = 2'd2
    } req_id_t;

    function automatic logic [2:0] req_onehot(input req_id_t id);
        return 3'b001 << id;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
//   Down-counter that tracks the RAM read latency. Loaded with LAT while the
//   arbiter is in ISSUE; 'last' marks the cycle on which ram_rdata is valid
//   and must be captured.
// Ports
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset
//   load  in   reload the counter with LAT
//   last  out  current cycle is the final wait cycle
// -----------------------------------------------------------------------------
module mem_lat_counter #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int CW = $clog2(LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign last = (cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-port instruction/data RAM among instruction fetch (f),
//   the load/store unit (d) and the debug/program loader (x). One access is
//   in flight at a time: grant -> ISSUE (ram_en) -> WAIT (RAM_LAT cycles) ->
//   RESP (owner rvalid). Priority x > d > f, with a starvation override that
//   lets f win after STARVE_LIM consecutive losses to d.
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   {f,d,x}_req/we/addr/wdata  requester access (req held until gnt)
//   {f,d,x}_gnt              combinational grant
//   {f,d,x}_rvalid/rdata     completion pulse and read data (0 for writes)
//   ram_en/we/addr/wdata     RAM command
//   ram_rdata                RAM read data, RAM_LAT cycles after ram_en
//   busy                     access in flight (ISSUE/WAIT/RESP)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic              f_we,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0] f_wdata,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              x_gnt,
    output logic              x_rvalid,
    output logic [DATA_W-1:0] x_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    state_t            state;
    req_id_t           owner;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        rvalid_q;
    logic [SW-1:0]     starve_cnt;
    logic              cap_last;

    logic              arb_ok;
    logic              grant;
    logic              starved;
    req_id_t           win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    mem_lat_counter #(
        .LAT (RAM_LAT)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (state == ISSUE),
        .last (cap_last)
    );

    // Arbitration: only in IDLE/RESP and never while reset is asserted, so
    // no grant can leak out during reset even though gnt is combinational.
    always_comb begin
        arb_ok  = rst && ((state == IDLE) || (state == RESP));
        starved = (starve_cnt == SW'(STARVE_LIM));
        grant   = arb_ok && (f_req || d_req || x_req);

        win = REQ_F;
        if (x_req) begin
            win = REQ_X;
        end else if (f_req && starved) begin
            win = REQ_F;
        end else if (d_req) begin
            win = REQ_D;
        end

        win_we    = f_we;
        win_addr  = f_addr;
        win_wdata = f_wdata;
        case (win)
            REQ_D: begin
                win_we    = d_we;
                win_addr  = d_addr;
                win_wdata = d_wdata;
            end
            REQ_X: begin
                win_we    = x_we;
                win_addr  = x_addr;
                win_wdata = x_wdata;
            end
            default: ;
        endcase
    end

    assign f_gnt = grant && (win == REQ_F);
    assign d_gnt = grant && (win == REQ_D);
    assign x_gnt = grant && (win == REQ_X);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= REQ_F;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            starve_cnt <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            rvalid_q <= '0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;

            // Counts only arbitrations f lost to d; x wins leave it untouched.
            if (!f_req || f_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            case (state)
                // Grant edge: latch the winner's command into the RAM port
                IDLE, RESP: begin
                    if (grant) begin
                        state     <= ISSUE;
                        owner     <= win;
                        we_q      <= win_we;
                        ram_en    <= 1'b1;
                        ram_we    <= win_we;
                        ram_addr  <= win_addr;
                        ram_wdata <= win_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                // Command on the RAM port this cycle
                ISSUE: state <= WAIT;
                // Capture read data on the final latency cycle
                WAIT: begin
                    if (cap_last) begin
                        state    <= RESP;
                        rvalid_q <= req_onehot(owner);
                        rdata_q  <= we_q ? '0 : ram_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign f_rvalid = rvalid_q[REQ_F];
    assign d_rvalid = rvalid_q[REQ_D];
    assign x_rvalid = rvalid_q[REQ_X];

    assign f_rdata = f_rvalid ? rdata_q : '0;
    assign d_rdata = d_rvalid ? rdata_q : '0;
    assign x_rdata = x_rvalid ? rdata_q : '0;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (RAM_LAT=1, STARVE_LIM=4) with a
//   behavioural one-cycle-latency RAM. Inputs are driven 1 time unit after
//   the rising edge and outputs sampled shortly afterwards.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          f_req, f_we, d_req, d_we, x_req, x_we;
    logic [AW-1:0] f_addr, d_addr, x_addr;
    logic [DW-1:0] f_wdata, d_wdata, x_wdata;
    logic          f_gnt, d_gnt, x_gnt;
    logic          f_rvalid, d_rvalid, x_rvalid;
    logic [DW-1:0] f_rdata, d_rdata, x_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RAM_LAT    (1),
        .STARVE_LIM (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_we      (f_we),
        .f_addr    (f_addr),
        .f_wdata   (f_wdata),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .x_req     (x_req),
        .x_we      (x_we),
        .x_addr    (x_addr),
        .x_wdata   (x_wdata),
        .x_gnt     (x_gnt),
        .x_rvalid  (x_rvalid),
        .x_rdata   (x_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, read data one cycle after ram_en; bench preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        nxt();
        pre_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b0;
        f_req = 0; f_we = 0; f_addr = '0; f_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        ram_rdata = '0;
        #1;
        preload(8'h05, 16'hA5A5);
        preload(8'h20, 16'h1111);
        preload(8'h21, 16'h2222);
        preload(8'h22, 16'h3333);
        preload(8'h10, 16'hFFFF);

        // Reset held with f requesting: everything quiet
        f_req = 1; f_addr = 8'h05;
        nxt(); nxt(); #1;
        chk("rst_gnt",    {x_gnt, d_gnt, f_gnt}, 3'b000);
        chk("rst_rvalid", {x_rvalid, d_rvalid, f_rvalid}, 3'b000);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_addr",   ram_addr, 8'h00);
        chk("rst_rdata",  f_rdata, 16'h0000);

        // Release: f granted same cycle; single read latency
        rst = 1; #1;
        chk("rel_gnt", {x_gnt, d_gnt, f_gnt}, 3'b001);
        nxt(); f_req = 0; #1;
        chk("rd_c1_en",   {ram_en, ram_we}, 2'b10);
        chk("rd_c1_addr", ram_addr, 8'h05);
        chk("rd_c1_busy", busy, 1'b1);
        nxt(); #1;
        chk("rd_c2_en", ram_en, 1'b0);
        chk("rd_c2_rv", {x_rvalid, d_rvalid, f_rvalid}, 3'b000);
        nxt(); #1;
        chk("rd_c3_rv",    {x_rvalid, d_rvalid, f_rvalid}, 3'b001);
        chk("rd_c3_rdata", f_rdata, 16'hA5A5);
        nxt(); #1;
        chk("rd_idle", {busy, f_rvalid}, 2'b00);

        // Contention: x, then d, then f
        f_req = 1; f_addr = 8'h20;
        d_req = 1; d_addr = 8'h21;
        x_req = 1; x_addr = 8'h22; #1;
        chk("con_g0", {x_gnt, d_gnt, f_gnt}, 3'b100);
        nxt(); x_req = 0; #1;
        chk("con_issue_nogrant", {x_gnt, d_gnt, f_gnt}, 3'b000);
        nxt(); #1;
        chk("con_wait_nogrant", {x_gnt, d_gnt, f_gnt}, 3'b000);
        nxt(); #1;
        chk("con_x_rv", {x_rvalid, d_rvalid, f_rvalid}, 3'b100);
        chk("con_x_rd", x_rdata, 16'h3333);
        chk("con_g1",   {x_gnt, d_gnt, f_gnt}, 3'b010);
        nxt(); d_req = 0; nxt(); nxt(); #1;
        chk("con_d_rv", {x_rvalid, d_rvalid, f_rvalid}, 3'b010);
        chk("con_d_rd", d_rdata, 16'h2222);
        chk("con_g2",   {x_gnt, d_gnt, f_gnt}, 3'b001);
        nxt(); f_req = 0; nxt(); nxt(); #1;
        chk("con_f_rv", {x_rvalid, d_rvalid, f_rvalid}, 3'b001);
        chk("con_f_rd", f_rdata, 16'h1111);
        chk("con_g3",   {x_gnt, d_gnt, f_gnt}, 3'b000);
        nxt();

        // Starvation: four d grants, then f
        f_req = 1; f_addr = 8'h20;
        d_req = 1; d_addr = 8'h21;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("starve_g%0d", i), {d_gnt, f_gnt}, (i < 4) ? 2'b10 : 2'b01);
            if (i < 4) begin
                nxt(); nxt(); nxt();
            end
        end
        nxt(); f_req = 0; nxt(); nxt();
        f_req = 1; #1;
        chk("starve_f_rv",  {f_rvalid, f_rdata}, {1'b1, 16'h1111});
        chk("starve_reset", {d_gnt, f_gnt}, 2'b10);
        nxt(); d_req = 0; f_req = 0; nxt(); nxt(); #1;
        chk("starve_d_rd", {d_rvalid, d_rdata}, {1'b1, 16'h2222});
        nxt();

        // Write then read
        x_req = 1; x_we = 1; x_addr = 8'h10; x_wdata = 16'h1234; #1;
        chk("wr_gnt", {x_gnt, d_gnt, f_gnt}, 3'b100);
        nxt(); x_req = 0; x_we = 0; #1;
        chk("wr_c1_cmd",   {ram_en, ram_we}, 2'b11);
        chk("wr_c1_addr",  ram_addr, 8'h10);
        chk("wr_c1_wdata", ram_wdata, 16'h1234);
        nxt(); nxt();
        d_req = 1; d_we = 0; d_addr = 8'h10; #1;
        chk("wr_rv",    {x_rvalid, d_rvalid, f_rvalid}, 3'b100);
        chk("wr_rdata", x_rdata, 16'h0000);
        chk("wr_d_gnt", {x_gnt, d_gnt, f_gnt}, 3'b010);
        nxt(); d_req = 0; nxt(); nxt(); #1;
        chk("rb_rv",    {x_rvalid, d_rvalid, f_rvalid}, 3'b010);
        chk("rb_rdata", d_rdata, 16'h1234);
        nxt();

        // Reset during WAIT drops the access
        f_req = 1; f_addr = 8'h05; #1;
        chk("mid_gnt", {x_gnt, d_gnt, f_gnt}, 3'b001);
        nxt(); f_req = 0; nxt();
        rst = 0; #1;
        chk("mid_rst_quiet", {busy, ram_en}, 2'b00);
        nxt(); rst = 1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            seen = seen | f_rvalid | d_rvalid | x_rvalid;
            nxt();
        end
        chk("mid_no_rvalid", seen, 1'b0);
        d_req = 1; d_addr = 8'h22; #1;
        chk("post_gnt", {x_gnt, d_gnt, f_gnt}, 3'b010);
        nxt(); d_req = 0; nxt(); nxt(); #1;
        chk("post_rv",    {x_rvalid, d_rvalid, f_rvalid}, 3'b010);
        chk("post_rdata", d_rdata, 16'h3333);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
